// File: rtl/ram_rom_banker.sv
// Banked 4K RAM/ROM windows, write protect, sticky violation flag and slow-ROM RDY stretch for a 6502 bus.
// Decode, selects and register read data are combinational; register writes commit 1 Clk after synced PHI2 falls.
// Stalls the CPU by pulling NRDY low for WAIT_STATES PHI2 cycles on slow ROM reads; writes never stall.
module ram_rom_banker #(
    parameter int          BANK_BITS    = 5,
    parameter int          NUM_WINDOWS  = 2,
    parameter logic [3:0]  WIN_TOP_PAGE = 4'hA,
    parameter logic [15:0] REG_BASE     = 16'hBFF8,
    parameter int          WAIT_STATES  = 1
) (
    input  logic                 Clk,
    input  logic                 NReset,
    input  logic                 PHI2,
    input  logic [15:0]          Addr,
    input  logic                 RW,
    inout  wire  [7:0]           Data,
    output logic [BANK_BITS-1:0] RA,
    output logic                 NRAMCS,
    output logic                 NROMCS,
    output logic                 NRDS,
    output logic                 NWDS,
    output logic                 NRDY
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_COMMIT} state_e;

    state_e               state_q, state_d;
    logic                 p2_meta_q, p2s_q, p2s_dly_q;
    logic                 p2_rise, p2_fall;
    logic                 start, latch_en, commit;
    logic [BANK_BITS-1:0] bank_q [NUM_WINDOWS];
    logic [2:0]           ctrl_q;
    logic                 wpv_q;
    logic [BANK_BITS-1:0] hold_q;
    logic [2:0]           tgt_q;
    logic                 wr_pend_q, rd_stat_q, wpv_pend_q;
    logic [3:0]           cnt_q, cnt_d;
    logic                 win_hit, win_ram, reg_hit, ram_sel, rom_sel, wp_block, slow_rd;
    logic [BANK_BITS-1:0] win_bank;
    logic [2:0]           off;
    logic [7:0]           rd_dat;

    assign off     = Addr[2:0];
    assign reg_hit = (Addr[15:3] == REG_BASE[15:3]);
    assign p2_rise = p2s_q & ~p2s_dly_q;
    assign p2_fall = ~p2s_q & p2s_dly_q;

    // PHI2 synchroniser; reset to "high" so a reset released mid-PHI2 never fakes a rising edge
    always_ff @(posedge Clk or negedge NReset) begin
        if (!NReset) begin
            p2_meta_q <= 1'b1;
            p2s_q     <= 1'b1;
            p2s_dly_q <= 1'b1;
        end else begin
            p2_meta_q <= PHI2;
            p2s_q     <= p2_meta_q;
            p2s_dly_q <= p2s_q;
        end
    end

    // Bus-cycle FSM state register
    always_ff @(posedge Clk or negedge NReset) begin
        if (!NReset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Bus-cycle FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (p2_rise) state_d = S_ACTIVE;
            S_ACTIVE: if (p2_fall) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Bus-cycle FSM outputs
    always_comb begin
        start    = (state_q == S_IDLE) && p2_rise;
        latch_en = (state_q == S_ACTIVE);
        commit   = (state_q == S_COMMIT);
    end

    // Window lookup: the windows occupy distinct pages, so at most one matches
    always_comb begin
        win_hit  = 1'b0;
        win_bank = '0;
        for (int i = 0; i < NUM_WINDOWS; i++) begin
            if (Addr[15:12] == 4'(WIN_TOP_PAGE - i)) begin
                win_hit  = 1'b1;
                win_bank = bank_q[i];
            end
        end
    end

    // Chip-select and upper-address decode; the register block suppresses both selects
    always_comb begin
        win_ram = win_hit && ctrl_q[0] && (win_bank == '0);
        ram_sel = 1'b0;
        rom_sel = 1'b0;
        RA      = '0;
        if (win_hit) begin
            ram_sel = win_ram;
            rom_sel = !win_ram;
            RA      = win_ram ? '0 : win_bank;
        end else if (!Addr[15]) begin
            ram_sel = 1'b1;
            RA      = BANK_BITS'(Addr[14:12]);
        end else if (Addr[15:14] == 2'b11) begin
            rom_sel = 1'b1;
            RA      = BANK_BITS'(Addr[15:12]);
        end
        wp_block = ctrl_q[1] && !RW && win_ram && !reg_hit;
        slow_rd  = win_hit && !win_ram && RW && ctrl_q[2];
        NRAMCS   = ~(ram_sel && !reg_hit);
        NROMCS   = ~(rom_sel && !reg_hit);
        NRDS     = ~(PHI2 && RW);
        NWDS     = ~(PHI2 && !RW && !wp_block);
    end

    // Register read mux
    always_comb begin
        rd_dat = 8'h00;
        for (int i = 0; i < NUM_WINDOWS; i++) begin
            if (off == 3'(i)) rd_dat = 8'(bank_q[i]);
        end
        if (off == 3'd6) rd_dat = {7'b0, wpv_q};
        if (off == 3'd7) rd_dat = {5'b0, ctrl_q};
    end

    assign Data = (PHI2 && RW && reg_hit) ? rd_dat : 8'hzz;

    // Capture what the current bus cycle will commit; the last written data value wins
    always_ff @(posedge Clk or negedge NReset) begin
        if (!NReset) begin
            hold_q     <= '0;
            tgt_q      <= '0;
            wr_pend_q  <= 1'b0;
            rd_stat_q  <= 1'b0;
            wpv_pend_q <= 1'b0;
        end else if (start) begin
            wr_pend_q  <= 1'b0;
            rd_stat_q  <= 1'b0;
            wpv_pend_q <= 1'b0;
        end else if (latch_en) begin
            if (!RW && reg_hit) begin
                hold_q    <= Data[BANK_BITS-1:0];
                tgt_q     <= off;
                wr_pend_q <= 1'b1;
            end
            if (RW && reg_hit && off == 3'd6) rd_stat_q  <= 1'b1;
            if (wp_block)                     wpv_pend_q <= 1'b1;
        end
    end

    // Commit register writes and STATUS side effects once PHI2 has fallen; a new violation beats a read-clear
    always_ff @(posedge Clk or negedge NReset) begin
        if (!NReset) begin
            for (int i = 0; i < NUM_WINDOWS; i++) bank_q[i] <= '0;
            ctrl_q <= '0;
            wpv_q  <= 1'b0;
        end else if (commit) begin
            if (wr_pend_q) begin
                for (int i = 0; i < NUM_WINDOWS; i++) begin
                    if (tgt_q == 3'(i)) bank_q[i] <= hold_q;
                end
                if (tgt_q == 3'd7) ctrl_q <= hold_q[2:0];
            end
            if (rd_stat_q)  wpv_q <= 1'b0;
            if (wpv_pend_q) wpv_q <= 1'b1;
        end
    end

    // Wait-state counter next value: load on a slow read's PHI2 rise, count down on PHI2 falls
    always_comb begin
        cnt_d = cnt_q;
        if (start && slow_rd && cnt_q == 4'd0) cnt_d = 4'(WAIT_STATES);
        else if (p2_fall && cnt_q != 4'd0)     cnt_d = cnt_q - 4'd1;
    end

    // Wait-state counter register
    always_ff @(posedge Clk or negedge NReset) begin
        if (!NReset) cnt_q <= 4'd0;
        else         cnt_q <= cnt_d;
    end

    assign NRDY = (cnt_q == 4'd0);

endmodule
